dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the core's MEM-stage load/store port.

---
 rtl/dmem_responder.sv | 98 +++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the MEM-stage load/store port.
// One request in flight; response returned LATENCY cycles after accept and held until consumed.
module dmem_responder #(
  parameter int BIT_WIDTH   = 32,
  parameter int ENTRY_COUNT = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0]  req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BIT_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | request accepted, latency counter running
  // RESP  | response presented, waiting for rsp_ready
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int         IDX_W    = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [BIT_WIDTH-1:0]  rdata_q;
  logic                  err_q;
  logic [BIT_WIDTH-1:0]  mem [ENTRY_COUNT];

  logic [ADDR_WIDTH-3:0] idx;
  logic [IDX_W-1:0]      word;
  logic                  dec_err;
  logic                  accept;

  assign idx     = req_addr[ADDR_WIDTH-1:2];
  assign word    = idx[IDX_W-1:0];
  assign dec_err = (req_addr[1:0] != 2'b00) || (idx >= (ADDR_WIDTH-2)'(ENTRY_COUNT));
  assign accept  = req_valid && req_ready;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Array has no reset: an accepted store survives a reset that lands mid-request.
  always_ff @(posedge clk) begin
    if (accept && req_we && !dec_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[word][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rdata_q <= (req_we || dec_err) ? '0 : mem[word];
            err_q   <= dec_err;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked against an array model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [2:0]            req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0][31:0]      req_addr, req_wdata, rsp_rdata;
  logic [2:0][3:0]       req_be;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] model_mem [3][32];
  int          last_acc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one transaction: store merges enabled bytes, load returns the word, errors return 0.
  task automatic model_apply(int k, bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                             output logic [31:0] exp_rd, output bit exp_err);
    int idx;
    exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32);
    exp_rd  = '0;
    if (!exp_err) begin
      idx = int'(addr >> 2);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = model_mem[k][idx];
      end
    end
  endtask

  // Called and returns at a negedge; hold = cycles rsp_ready stays low in RESP.
  task automatic txn(int k, bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                     int hold, bit chk_space);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          n;
    int          acc;
    model_apply(k, we, addr, wdata, be, exp_rd, exp_err);
    rsp_ready[k] = (hold == 0);
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_valid[k] = 1'b0;
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_we[k]    = 1'($urandom);
    req_be[k]    = 4'($urandom);
    if (chk_space) chk("spacing", 32'(acc - last_acc[k]), 32'(lat_of(k) + 1));
    last_acc[k] = acc;
    n = 1;
    while (!rsp_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat_of(k)));
    chk("rdata", rsp_rdata[k], exp_rd);
    chk("err", 32'(rsp_err[k]), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ctl", {rsp_valid[k], req_ready[k], busy[k], rsp_err[k]},
          {1'b1, 1'b0, 1'b1, exp_err});
      chk("hold_rdata", rsp_rdata[k], exp_rd);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    chk("idle_after", {rsp_valid[k], req_ready[k], busy[k]}, 3'b010);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          r;
    rst       = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      last_acc[k] = 0;
      for (int w = 0; w < 32; w++) model_mem[k][w] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ctl", {req_ready[k], rsp_valid[k], rsp_err[k], busy[k]}, 4'b1000);
      chk("rst_rdata", rsp_rdata[k], 32'h0);
    end

    txn(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b1, 32'h8, 32'h11223344, 4'b0101, 0, 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b0, 32'h6, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b0, 32'h80, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b1, 32'hA, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    txn(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    txn(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 5, 1'b0);

    // Reset lands in WAIT of a store on the LATENCY=15 instance.
    wd = $urandom;
    model_apply(2, 1'b1, 32'h4, wd, 4'hF, exp_rd, exp_err);
    req_we[2] = 1'b1; req_addr[2] = 32'h4; req_wdata[2] = wd; req_be[2] = 4'hF;
    req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy[2]), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst", {rsp_valid[2], busy[2]}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready[2]), 32'd1);
    txn(2, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0);

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 32; w++)
        txn(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      txn(k, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0);
      for (int i = 0; i < 5; i++)
        txn(k, 1'b0, 32'($urandom_range(0, 31) * 4), 32'h0, 4'h0, 0, 1'b1);
    end

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 50; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       addr = 32'($urandom_range(0, 31) * 4);
        else if (r == 6) addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        else if (r == 7) addr = 32'h7C;
        else if (r == 8) addr = 32'h80;
        else             addr = $urandom | 32'h80;
        txn(k, 1'($urandom), addr, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
